// File: rtl/system_top_mul_share_arb_if.sv
// Bus bundle for the shared-multiplier arbiter: packed requester operand lanes,
// the tagged valid/ready result channel and the busy flag.
interface system_top_mul_share_arb_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned A_W     = 28,
  parameter int unsigned B_W     = 32,
  parameter int unsigned P_W     = 54
);
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic                   res_valid;
  logic                   res_ready;
  logic [ID_W-1:0]        res_id;
  logic [P_W-1:0]         res_data;
  logic                   busy;

  // Requesters and result consumer side
  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_id, res_data, busy
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_id, res_data, busy
  );
endinterface

// File: rtl/system_top_mul_share_arb.sv
// Round-robin arbiter feeding one shared signed multiplier; results return tagged with the requester ID.
// Define SYSTEM_TOP_MUL_SHARE_ARB_PIPE3_EN to add a third output register stage (latency 3).
module system_top_mul_share_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned A_W     = 28,
  parameter int unsigned B_W     = 32,
  parameter int unsigned P_W     = 54
) (
  input logic                   ap_clk,
  input logic                   ap_rst,
  system_top_mul_share_arb_if.slave bus
);

  localparam int unsigned PROD_W = A_W + B_W;

  logic [A_W-1:0]     a_lane [NUM_REQ];
  logic [B_W-1:0]     b_lane [NUM_REQ];
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    grant;
  logic               found;
  logic               en;
  logic               xfer;
  logic               out_v;
  logic [NUM_REQ-1:0] ready;

  logic               s1_v;
  logic [ID_W-1:0]    s1_id;
  logic [A_W-1:0]     s1_a;
  logic [B_W-1:0]     s1_b;
  logic               s2_v;
  logic [ID_W-1:0]    s2_id;
  logic [P_W-1:0]     s2_p;
  logic               busy_q;

  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] b_ext;
  logic signed [PROD_W-1:0] prod_full;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign a_lane[gi] = bus.req_a[gi*A_W +: A_W];
    assign b_lane[gi] = bus.req_b[gi*B_W +: B_W];
  end

`ifdef SYSTEM_TOP_MUL_SHARE_ARB_PIPE3_EN
  logic               s3_v;
  logic [ID_W-1:0]    s3_id;
  logic [P_W-1:0]     s3_p;
  assign out_v = s3_v;
`else
  assign out_v = s2_v;
`endif

  assign en = !out_v || bus.res_ready;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && bus.req_valid[ID_W'((32'(rr_ptr) + k) % NUM_REQ)]) begin
        found = 1'b1;
        grant = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign xfer = found && en && !ap_rst;

  always_comb begin
    ready = '0;
    if (xfer) ready[grant] = 1'b1;
  end

  // Full-width signed product; only the low P_W bits are kept (wraparound)
  assign a_ext     = PROD_W'($signed(s1_a));
  assign b_ext     = PROD_W'($signed(s1_b));
  assign prod_full = a_ext * b_ext;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      rr_ptr <= '0;
      s1_v   <= 1'b0;
      s1_id  <= '0;
      s1_a   <= '0;
      s1_b   <= '0;
      s2_v   <= 1'b0;
      s2_id  <= '0;
      s2_p   <= '0;
      busy_q <= 1'b0;
`ifdef SYSTEM_TOP_MUL_SHARE_ARB_PIPE3_EN
      s3_v   <= 1'b0;
      s3_id  <= '0;
      s3_p   <= '0;
`endif
    end else if (en) begin
      if (xfer) begin
        rr_ptr <= ID_W'((32'(grant) + 1) % NUM_REQ);
        s1_a   <= a_lane[grant];
        s1_b   <= b_lane[grant];
      end
      s1_v  <= xfer;
      s1_id <= grant;
      s2_v  <= s1_v;
      s2_id <= s1_id;
      s2_p  <= prod_full[P_W-1:0];
`ifdef SYSTEM_TOP_MUL_SHARE_ARB_PIPE3_EN
      s3_v   <= s2_v;
      s3_id  <= s2_id;
      s3_p   <= s2_p;
      busy_q <= xfer || s1_v || s2_v;
`else
      busy_q <= xfer || s1_v;
`endif
    end
  end

  assign bus.req_ready = ready;
  assign bus.busy      = busy_q;
`ifdef SYSTEM_TOP_MUL_SHARE_ARB_PIPE3_EN
  assign bus.res_valid = s3_v;
  assign bus.res_id    = s3_id;
  assign bus.res_data  = s3_p;
`else
  assign bus.res_valid = s2_v;
  assign bus.res_id    = s2_id;
  assign bus.res_data  = s2_p;
`endif

endmodule

// File: tb/tb_system_top_mul_share_arb.sv
// Directed bench for system_top_mul_share_arb: reset, single request, sparse and full
// round-robin, async reset mid-flight, backpressure and product truncation.
module tb_system_top_mul_share_arb;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int A_W     = 28;
  localparam int B_W     = 32;
  localparam int P_W     = 54;
`ifdef SYSTEM_TOP_MUL_SHARE_ARB_PIPE3_EN
  localparam int STAGES  = 3;
`else
  localparam int STAGES  = 2;
`endif

  logic ap_clk;
  logic ap_rst;
  int   npass;
  int   ntotal;
  int   nfail;
  logic [63:0] exp_p [4];

  system_top_mul_share_arb_if #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .A_W(A_W), .B_W(B_W), .P_W(P_W)
  ) bus ();

  system_top_mul_share_arb #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .A_W(A_W), .B_W(B_W), .P_W(P_W)
  ) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    bus.req_a[i*A_W +: A_W] = a;
    bus.req_b[i*B_W +: B_W] = b;
  endtask

  initial begin
    npass  = 0;
    ntotal = 0;
    nfail  = 0;
    exp_p[0] = 64'd10;
    exp_p[1] = 64'd40;
    exp_p[2] = 64'd90;
    exp_p[3] = 64'd160;

    // Reset state, with requests pending
    ap_rst        = 1'b1;
    bus.req_valid = 4'hF;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b1;
    #12;
    chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
    chk("rst_res_valid", 64'(bus.res_valid), 64'h0);
    chk("rst_busy",      64'(bus.busy),      64'h0);
    chk("rst_res_data",  64'(bus.res_data),  64'h0);
    chk("rst_res_id",    64'(bus.res_id),    64'h0);
    bus.req_valid = 4'h0;
    tick();
    ap_rst = 1'b0;

    // Single request from requester 2: -3 * 5
    set_op(2, 28'hFFFFFFD, 32'd5);
    bus.req_valid = 4'b0100;
    #1;
    chk("single_ready", 64'(bus.req_ready), 64'b0100);
    tick();
    bus.req_valid = 4'h0;
    chk("single_v_early", 64'(bus.res_valid), 64'h0);
    chk("single_busy",    64'(bus.busy),      64'h1);
    for (int i = 0; i < STAGES - 2; i++) begin
      tick();
      chk("single_v_wait", 64'(bus.res_valid), 64'h0);
    end
    tick();
    chk("single_v",    64'(bus.res_valid), 64'h1);
    chk("single_id",   64'(bus.res_id),    64'h2);
    chk("single_data", 64'(bus.res_data),  64'h3FFFFFFFFFFFF1);
    tick();
    chk("single_v_off",  64'(bus.res_valid), 64'h0);
    chk("single_idle",   64'(bus.busy),      64'h0);

    // Pointer is 3; requester 0 alone wraps and moves the pointer to 1
    bus.req_valid = 4'b0001;
    #1;
    chk("wrap_ready", 64'(bus.req_ready), 64'b0001);
    tick();

    // Sparse: 3 and 0 valid with pointer 1 -> 3, then 0, pointer back to 1
    bus.req_valid = 4'b1001;
    #1;
    chk("sparse_g3", 64'(bus.req_ready), 64'b1000);
    tick();
    #1;
    chk("sparse_g0", 64'(bus.req_ready), 64'b0001);
    tick();
    bus.req_valid = 4'hF;
    #1;
    chk("sparse_ptr1", 64'(bus.req_ready), 64'b0010);
    bus.req_valid = 4'h0;
    repeat (STAGES + 1) tick();

    // Fill two stages, then async reset between edges
    for (int i = 0; i < NUM_REQ; i++) set_op(i, A_W'(i + 1), B_W'(10 * (i + 1)));
    bus.req_valid = 4'hF;
    tick();
    tick();
    chk("pre_rst_busy", 64'(bus.busy), 64'h1);
    #2;
    ap_rst = 1'b1;
    #1;
    chk("mid_rst_res_valid", 64'(bus.res_valid), 64'h0);
    chk("mid_rst_busy",      64'(bus.busy),      64'h0);
    chk("mid_rst_req_ready", 64'(bus.req_ready), 64'h0);
    tick();
    ap_rst = 1'b0;
    #1;
    chk("post_rst_grant0", 64'(bus.req_ready), 64'b0001);

    // Fairness: all valid for 8 transfers, grants and ids cycle 0..3
    for (int t = 0; t < 8 + STAGES - 1; t++) begin
      bus.req_valid = (t < 8) ? 4'hF : 4'h0;
      #1;
      chk("fair_ready", 64'(bus.req_ready), (t < 8) ? 64'(4'b0001 << (t % 4)) : 64'h0);
      tick();
      if (t >= STAGES - 1) begin
        chk("fair_v",    64'(bus.res_valid), 64'h1);
        chk("fair_id",   64'(bus.res_id),    64'((t - (STAGES - 1)) % 4));
        chk("fair_data", 64'(bus.res_data),  exp_p[(t - (STAGES - 1)) % 4]);
      end else begin
        chk("fair_fill_v", 64'(bus.res_valid), 64'h0);
      end
    end
    tick();
    chk("fair_drained", 64'(bus.res_valid), 64'h0);

    // Backpressure: stream k*3 from requester 1, then stall 3 cycles
    bus.req_valid = 4'b0010;
    for (int k = 1; k <= STAGES; k++) begin
      set_op(1, A_W'(k), 32'd3);
      #1;
      chk("bp_ready", 64'(bus.req_ready), 64'b0010);
      tick();
    end
    set_op(1, A_W'(STAGES + 1), 32'd3);
    bus.res_ready = 1'b0;
    #1;
    chk("bp_stall_ready", 64'(bus.req_ready), 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_v",     64'(bus.res_valid), 64'h1);
      chk("bp_hold_data",  64'(bus.res_data),  64'd3);
      chk("bp_hold_id",    64'(bus.res_id),    64'h1);
      chk("bp_hold_ready", 64'(bus.req_ready), 64'h0);
      chk("bp_hold_busy",  64'(bus.busy),      64'h1);
    end
    bus.res_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(bus.req_ready), 64'b0010);
    for (int k = 2; k <= STAGES + 1; k++) begin
      tick();
      bus.req_valid = 4'h0;
      chk("bp_v",    64'(bus.res_valid), 64'h1);
      chk("bp_data", 64'(bus.res_data),  64'(3 * k));
    end
    tick();
    chk("bp_done_v",    64'(bus.res_valid), 64'h0);
    chk("bp_done_busy", 64'(bus.busy),      64'h0);

    // Truncation to 54 bits, requester 2 (pointer is 2 after the stream)
    set_op(2, 28'h7FFFFFF, 32'h7FFFFFFF);
    bus.req_valid = 4'b0100;
    #1;
    chk("trunc_ready", 64'(bus.req_ready), 64'b0100);
    tick();
    set_op(2, 28'h8000000, 32'h80000000);
    tick();
    bus.req_valid = 4'h0;
    repeat (STAGES - 2) tick();
    chk("trunc_max_v",    64'(bus.res_valid), 64'h1);
    chk("trunc_max_data", 64'(bus.res_data),  64'h3FFFFF78000001);
    tick();
    chk("trunc_min_v",    64'(bus.res_valid), 64'h1);
    chk("trunc_min_id",   64'(bus.res_id),    64'h2);
    chk("trunc_min_data", 64'(bus.res_data),  64'h0);
    tick();
    chk("trunc_done", 64'(bus.res_valid), 64'h0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
